// File: rtl/dsp_pkg.sv
// Shared DSP definitions: sample/gain widths, limiter state encoding and
// the 16-bit saturation helper used across the audio chain.
package dsp_pkg;

  localparam int SAMPLE_W = 16;
  localparam int GAIN_W   = 9;

  localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;

  localparam logic [1:0] LIM_IDLE    = 2'd0;
  localparam logic [1:0] LIM_ATTACK  = 2'd1;
  localparam logic [1:0] LIM_HOLD    = 2'd2;
  localparam logic [1:0] LIM_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = LIM_IDLE,
    ST_ATTACK  = LIM_ATTACK,
    ST_HOLD    = LIM_HOLD,
    ST_RELEASE = LIM_RELEASE
  } lim_state_e;

  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [31:0] v);
    logic signed [SAMPLE_W-1:0] r;
    if (v > 32'sd32767) begin
      r = 16'sh7FFF;
    end else if (v < -32'sd32768) begin
      r = 16'sh8000;
    end else begin
      r = v[SAMPLE_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/limiter_gain_ctrl.sv
// Gain control for the peak limiter: level detect, attack/hold/release FSM,
// hold counter and Q8 gain register. Advances only on accepted samples.
module limiter_gain_ctrl
  import dsp_pkg::*;
#(
  parameter logic signed [SAMPLE_W-1:0] THRESHOLD    = 16'sd16000,
  parameter logic [GAIN_W-1:0]          ATTACK_STEP  = 9'd16,
  parameter logic [GAIN_W-1:0]          RELEASE_STEP = 9'd2,
  parameter logic [7:0]                 HOLD_SAMPLES = 8'd64,
  parameter logic [GAIN_W-1:0]          MIN_GAIN     = 9'd64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  output logic [GAIN_W-1:0]          gain,
  output logic                       limiting
);

  lim_state_e                 state_r, state_nxt_s;
  logic [GAIN_W-1:0]          gain_r, gain_nxt_s, atk_gain_s, rel_gain_s;
  logic [7:0]                 hold_cnt_r, hold_cnt_nxt_s;
  logic                       limiting_r;
  logic signed [SAMPLE_W-1:0] abs_s;
  logic                       over_s;

  // Magnitude detect; the most negative code folds to full scale.
  always_comb begin
    abs_s = in_sample;
    if (in_sample == 16'sh8000) begin
      abs_s = 16'sh7FFF;
    end else if (in_sample < 16'sd0) begin
      abs_s = -in_sample;
    end else begin
      abs_s = in_sample;
    end
    over_s = (abs_s > THRESHOLD);
  end

  // Clamped attack and release gain candidates.
  always_comb begin
    atk_gain_s = gain_r;
    rel_gain_s = gain_r;
    if (gain_r <= (MIN_GAIN + ATTACK_STEP)) begin
      atk_gain_s = MIN_GAIN;
    end else begin
      atk_gain_s = gain_r - ATTACK_STEP;
    end
    if (gain_r >= (GAIN_UNITY - RELEASE_STEP)) begin
      rel_gain_s = GAIN_UNITY;
    end else begin
      rel_gain_s = gain_r + RELEASE_STEP;
    end
  end

  // Next-state, gain and hold counter evaluation per accepted sample.
  always_comb begin
    state_nxt_s    = state_r;
    gain_nxt_s     = gain_r;
    hold_cnt_nxt_s = hold_cnt_r;
    if (!in_valid) begin
      state_nxt_s    = state_r;
    end else if (!enable) begin
      state_nxt_s    = ST_IDLE;
      gain_nxt_s     = GAIN_UNITY;
      hold_cnt_nxt_s = 8'd0;
    end else if (over_s) begin
      state_nxt_s    = ST_ATTACK;
      gain_nxt_s     = atk_gain_s;
      hold_cnt_nxt_s = HOLD_SAMPLES;
    end else begin
      case (state_r)
        ST_ATTACK, ST_HOLD: begin
          if (hold_cnt_r != 8'd0) begin
            state_nxt_s    = ST_HOLD;
            hold_cnt_nxt_s = hold_cnt_r - 8'd1;
          end else begin
            gain_nxt_s  = rel_gain_s;
            state_nxt_s = (rel_gain_s == GAIN_UNITY) ? ST_IDLE : ST_RELEASE;
          end
        end
        ST_RELEASE, ST_IDLE: begin
          // In IDLE the gain is already unity, so the release clamp keeps it there.
          gain_nxt_s  = rel_gain_s;
          state_nxt_s = (rel_gain_s == GAIN_UNITY) ? ST_IDLE : ST_RELEASE;
        end
        default: begin
          state_nxt_s    = ST_IDLE;
          gain_nxt_s     = GAIN_UNITY;
          hold_cnt_nxt_s = 8'd0;
        end
      endcase
    end
  end

  // State, gain and hold counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      gain_r     <= GAIN_UNITY;
      hold_cnt_r <= 8'd0;
      limiting_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      gain_r     <= gain_nxt_s;
      hold_cnt_r <= hold_cnt_nxt_s;
      limiting_r <= (state_nxt_s != ST_IDLE);
    end
  end

  assign gain     = gain_r;
  assign limiting = limiting_r;

endmodule

// File: rtl/peak_limiter.sv
// Feed-forward peak limiter: gain control plus a 2-stage
// multiply / round / saturate pipeline with bypass.
module peak_limiter
  import dsp_pkg::*;
#(
  parameter logic signed [SAMPLE_W-1:0] THRESHOLD    = 16'sd16000,
  parameter logic [GAIN_W-1:0]          ATTACK_STEP  = 9'd16,
  parameter logic [GAIN_W-1:0]          RELEASE_STEP = 9'd2,
  parameter logic [7:0]                 HOLD_SAMPLES = 8'd64,
  parameter logic [GAIN_W-1:0]          MIN_GAIN     = 9'd64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  output logic                       out_valid,
  output logic signed [SAMPLE_W-1:0] out_sample,
  output logic [GAIN_W-1:0]          gain_out,
  output logic                       limiting
);

  logic [GAIN_W-1:0]          gain_s;
  logic                       limiting_s;
  logic                       s1_valid_r;
  logic signed [SAMPLE_W-1:0] s1_sample_r;
  logic [GAIN_W-1:0]          s1_gain_r;
  logic signed [25:0]         product_s, rounded_s;
  logic signed [SAMPLE_W-1:0] sat_s;
  logic                       out_valid_r;
  logic signed [SAMPLE_W-1:0] out_sample_r;

  limiter_gain_ctrl #(
    .THRESHOLD    (THRESHOLD),
    .ATTACK_STEP  (ATTACK_STEP),
    .RELEASE_STEP (RELEASE_STEP),
    .HOLD_SAMPLES (HOLD_SAMPLES),
    .MIN_GAIN     (MIN_GAIN)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_sample (in_sample),
    .gain      (gain_s),
    .limiting  (limiting_s)
  );

  // Stage 1: capture sample with its pre-update gain (unity in bypass).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s1_sample_r <= 16'sd0;
      s1_gain_r   <= GAIN_UNITY;
    end else begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_sample_r <= in_sample;
        s1_gain_r   <= enable ? gain_s : GAIN_UNITY;
      end
    end
  end

  // Q8 multiply, round half up, saturate.
  always_comb begin
    product_s = 26'(s1_sample_r) * 26'($signed({1'b0, s1_gain_r}));
    rounded_s = (product_s + 26'sd128) >>> 8;
    sat_s     = sat16(32'(rounded_s));
  end

  // Stage 2: registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_sample_r <= 16'sd0;
    end else begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_sample_r <= sat_s;
      end
    end
  end

  assign out_valid  = out_valid_r;
  assign out_sample = out_sample_r;
  assign gain_out   = gain_s;
  assign limiting   = limiting_s;

endmodule

// File: tb/tb_peak_limiter.sv
// Self-checking bench for peak_limiter: directed vector table, hand-written
// sustained/recovery and reset sequences, and randomized traffic vs. a model.
module tb_peak_limiter;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic               in_valid;
  logic signed [15:0] in_sample;
  logic               out_valid;
  logic signed [15:0] out_sample;
  logic [8:0]         gain_out;
  logic               limiting;

  peak_limiter dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .out_valid  (out_valid),
    .out_sample (out_sample),
    .gain_out   (gain_out),
    .limiting   (limiting)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_gain = 256;
  int m_hold = 0;
  bit pend_v = 1'b0;
  int pend_s = 0;

  typedef struct {
    bit v; bit en; int s;
    bit ov; int os; int g; int h; bit lim;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_out(input int s, input int g);
    int p, q;
    p = s * g + 128;
    if (p >= 0) q = p / 256;
    else q = -((-p + 255) / 256);
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  // One clock: drive at negedge, update model, compare #1 after posedge.
  task automatic cycle(input bit v, input bit en, input int s);
    bit cur_v;
    int cur_s, mag;
    @(negedge clk);
    in_valid  = v;
    enable    = en;
    in_sample = 16'(s);
    @(posedge clk);
    #1;
    cur_v = v;
    cur_s = 0;
    if (v) begin
      cur_s = ref_out(s, en ? m_gain : 256);
      mag = (s < 0) ? -s : s;
      if (mag > 32767) mag = 32767;
      if (!en) begin
        m_gain = 256; m_hold = 0;
      end else if (mag > 16000) begin
        m_gain = (m_gain - 16 < 64) ? 64 : m_gain - 16;
        m_hold = 64;
      end else if (m_hold > 0) begin
        m_hold = m_hold - 1;
      end else begin
        m_gain = (m_gain + 2 > 256) ? 256 : m_gain + 2;
      end
    end
    chk("out_valid", int'(out_valid), int'(pend_v));
    if (pend_v) chk("out_sample", int'(out_sample), pend_s);
    chk("gain_out", int'(gain_out), m_gain);
    chk("limiting", int'(limiting), int'(m_gain != 256));
    chk("hold_cnt", int'(dut.u_ctrl.hold_cnt_r), m_hold);
    pend_v = cur_v;
    pend_s = cur_s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; enable = 1'b1; in_sample = 16'sd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sample", int'(out_sample), 0);
    chk("rst_gain", int'(gain_out), 256);
    chk("rst_limiting", int'(limiting), 0);
    chk("rst_hold", int'(dut.u_ctrl.hold_cnt_r), 0);
    @(negedge clk);
    rst = 1'b0;
    m_gain = 256; m_hold = 0; pend_v = 1'b0; pend_s = 0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; in_valid = 1'b0; in_sample = 16'sd0;
    do_reset();

    // v en sample | out_valid out_sample gain hold limiting (after that edge)
    tbl[0]  = '{1'b1, 1'b1,   1000, 1'b0,      0, 256,  0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1,  -1000, 1'b1,   1000, 256,  0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1,      0, 1'b1,  -1000, 256,  0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1,      0, 1'b0,      0, 256,  0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1,  20000, 1'b0,      0, 240, 64, 1'b1};
    tbl[5]  = '{1'b1, 1'b1,  20000, 1'b1,  20000, 224, 64, 1'b1};
    tbl[6]  = '{1'b0, 1'b1,      0, 1'b1,  18750, 224, 64, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, -20000, 1'b0,      0, 208, 64, 1'b1};
    tbl[8]  = '{1'b1, 1'b1,  30000, 1'b1, -17500, 192, 64, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, -32768, 1'b1,  24375, 176, 64, 1'b1};
    tbl[10] = '{1'b1, 1'b1,  20000, 1'b1, -24576, 160, 64, 1'b1};
    tbl[11] = '{1'b1, 1'b1,  20000, 1'b1,  13750, 144, 64, 1'b1};
    tbl[12] = '{1'b1, 1'b1,  20000, 1'b1,  12500, 128, 64, 1'b1};
    tbl[13] = '{1'b1, 1'b1,     -3, 1'b1,  11250, 128, 63, 1'b1};
    tbl[14] = '{1'b1, 1'b0,  30000, 1'b1,     -1, 256,  0, 1'b0};
    tbl[15] = '{1'b1, 1'b1, -32768, 1'b1,  30000, 240, 64, 1'b1};
    tbl[16] = '{1'b1, 1'b0, -32768, 1'b1, -32768, 256,  0, 1'b0};
    tbl[17] = '{1'b0, 1'b1,      0, 1'b1, -32768, 256,  0, 1'b0};
    tbl[18] = '{1'b0, 1'b1,      0, 1'b0,      0, 256,  0, 1'b0};

    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].v, tbl[i].en, tbl[i].s);
      chk($sformatf("tbl%0d_ov", i), int'(out_valid), int'(tbl[i].ov));
      if (tbl[i].ov) chk($sformatf("tbl%0d_os", i), int'(out_sample), tbl[i].os);
      chk($sformatf("tbl%0d_gain", i), int'(gain_out), tbl[i].g);
      chk($sformatf("tbl%0d_hold", i), int'(dut.u_ctrl.hold_cnt_r), tbl[i].h);
      chk($sformatf("tbl%0d_lim", i), int'(limiting), int'(tbl[i].lim));
    end

    // sustained peak down to the floor
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b1, 1'b1, 30000);
      chk("sus_gain", int'(gain_out), (k < 12) ? 256 - 16 * k : 64);
    end
    chk("sus_out", int'(out_sample), 7500);

    // hold phase with an in_valid gap, then release back to unity
    for (int k = 1; k <= 64; k++) begin
      cycle(1'b1, 1'b1, 0);
      chk("hold_gain", int'(gain_out), 64);
      if (k == 10) begin
        for (int j = 0; j < 5; j++) cycle(1'b0, 1'b1, 0);
        chk("gap_hold", int'(dut.u_ctrl.hold_cnt_r), 54);
        chk("gap_gain", int'(gain_out), 64);
      end
    end
    for (int k = 1; k <= 96; k++) begin
      cycle(1'b1, 1'b1, 0);
      chk("rel_gain", int'(gain_out), 64 + 2 * k);
      chk("rel_lim", int'(limiting), int'(k < 96));
    end

    // randomized traffic in alternating loud/quiet segments
    for (int it = 0; it < 2400; it++) begin
      int loud_pct, s;
      bit v, en;
      loud_pct = ((it / 300) % 2 == 1) ? 60 : 2;
      v  = ($urandom_range(3, 0) != 0);
      en = ($urandom_range(31, 0) != 0);
      if ($urandom_range(99, 0) < loud_pct) begin
        case ($urandom_range(2, 0))
          0: s = int'($urandom_range(32767, 16001));
          1: s = -int'($urandom_range(32768, 16001));
          default: s = ($urandom_range(1, 0) == 1) ? 16001 : -16001;
        endcase
      end else begin
        case ($urandom_range(2, 0))
          0: s = int'($urandom_range(16000, 0));
          1: s = -int'($urandom_range(16000, 0));
          default: s = ($urandom_range(1, 0) == 1) ? 16000 : -16000;
        endcase
      end
      cycle(v, en, s);
    end

    // reset with three samples in flight
    cycle(1'b1, 1'b1, 25000);
    cycle(1'b1, 1'b1, -25000);
    cycle(1'b1, 1'b1, 12345);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_out_sample", int'(out_sample), 0);
    chk("mid_rst_gain", int'(gain_out), 256);
    chk("mid_rst_limiting", int'(limiting), 0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_gain = 256; m_hold = 0; pend_v = 1'b0; pend_s = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b1, 0);
      chk("post_rst_no_stale", int'(out_valid), 0);
    end
    cycle(1'b1, 1'b1, 500);
    cycle(1'b0, 1'b1, 0);
    chk("post_rst_first_out", int'(out_sample), 500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
